line_fetcher: RTL and testbench

- Upstream feeder for the video signal generator's line buffer.
- On each new raster line reported by the generator, fetches the next line's luminance bytes from frame memory and pushes them into the line buffer via a write/ready handshake.
- Lines outside the active region get a constant blank level, with no memory traffic.
- Sits between the frame-memory read port and the generator's data_i/write/ready/line interface.

---
 rtl/line_fetcher.sv | 200 ++++++++++++++++++++
 tb/tb_line_fetcher.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetcher.sv
// line_fetcher: feeds the video generator's line buffer one raster line ahead.
//
// When the generator's line number changes, the block works out the next line
// (nl). Active lines are read byte by byte from frame memory, with at most one
// read outstanding, and pushed to the line buffer over a write/ready
// handshake. Non-active lines push BLANK_LEVEL with no memory traffic.
//
// Ports:
//   clk       system clock, all logic on posedge
//   reset     asynchronous active-low reset
//   line_i    current raster line from the generator
//   ready_i   line buffer accepts a byte this cycle
//   write_o   byte valid to line buffer
//   data_o    byte to line buffer
//   mem_addr  frame-memory read address (held while a read is outstanding)
//   mem_rd    one-cycle read request
//   mem_data  read data
//   mem_valid read data valid
//   busy      a line fetch is in progress
//   overrun   one-cycle pulse: line changed before the fetch finished
//
// Build option: define LINE_FETCHER_TESTPAT_EN to replace the memory fetch on
// active lines with a generated bar pattern pushed at blank-line speed.
module line_fetcher #(
    parameter int unsigned PIXELS       = 256,
    parameter int unsigned TOTAL_LINES  = 262,
    parameter int unsigned ACTIVE_FIRST = 20,
    parameter int unsigned ACTIVE_LINES = 200,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned BASE_ADDR    = 0,
    parameter logic [7:0]  BLANK_LEVEL  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        line_i,
    input  logic              ready_i,
    output logic              write_o,
    output logic [7:0]        data_o,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              busy,
    output logic              overrun
);

`ifdef LINE_FETCHER_TESTPAT_EN
    localparam bit UseMem = 1'b0;
`else
    localparam bit UseMem = 1'b1;
`endif

    // StDrain waits out a read issued for an abandoned line; StRestart is the
    // one-cycle gap that drops write_o before the new line starts.
    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StPush, StBlank, StDrain, StRestart
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        line_q;
    logic              hist_vld_q;
    logic [8:0]        nl_q, nl_d;
    logic              act_q, act_d;
    logic [8:0]        pix_q, pix_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;

    logic [8:0] line_inc;
    logic [8:0] nl_new;
    logic       nl_new_act;
    logic       start;
    logic       accept;
    logic       last_pix;
    logic       rd_outstanding;

    assign line_inc   = {1'b0, line_i} + 9'd1;
    assign nl_new     = (32'(line_inc) >= TOTAL_LINES) ? 9'd0 : line_inc;
    assign nl_new_act = (32'(nl_new) >= ACTIVE_FIRST) &&
                        (32'(nl_new) < ACTIVE_FIRST + ACTIVE_LINES);
    // History is invalid until the first clock after reset, so release alone
    // never looks like a line change.
    assign start      = hist_vld_q && (line_i != line_q);
    assign accept     = write_o && ready_i;
    assign last_pix   = (32'(pix_q) == PIXELS - 1);
    // A read is in flight if it was issued this cycle or is still unanswered.
    assign rd_outstanding = (state_q == StReq) ||
                            (((state_q == StWait) || (state_q == StDrain)) && !mem_valid);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            line_q     <= 8'd0;
            hist_vld_q <= 1'b0;
            nl_q       <= 9'd0;
            act_q      <= 1'b0;
            pix_q      <= 9'd0;
            data_q     <= 8'd0;
            addr_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_i;
            hist_vld_q <= 1'b1;
            nl_q       <= nl_d;
            act_q      <= act_d;
            pix_q      <= pix_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        nl_d      = nl_q;
        act_d     = act_q;
        pix_d     = pix_q;
        data_d    = data_q;
        overrun_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nl_d    = nl_new;
                    act_d   = nl_new_act;
                    pix_d   = 9'd0;
                    state_d = (nl_new_act && UseMem) ? StReq : StBlank;
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (mem_valid) begin
                    data_d  = mem_data;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (accept) begin
                    pix_d   = last_pix ? 9'd0 : pix_q + 9'd1;
                    state_d = last_pix ? StIdle : StReq;
                end
            end
            StBlank: begin
                if (accept) begin
                    pix_d   = last_pix ? 9'd0 : pix_q + 9'd1;
                    state_d = last_pix ? StIdle : StBlank;
                end
            end
            StDrain: begin
                if (mem_valid) state_d = StRestart;
            end
            StRestart: state_d = (act_q && UseMem) ? StReq : StBlank;
            default: state_d = StIdle;
        endcase

        // Line change mid-fetch: abandon the line and restart for the new nl.
        if (start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
            nl_d      = nl_new;
            act_d     = nl_new_act;
            pix_d     = 9'd0;
            state_d   = rd_outstanding ? StDrain : StRestart;
        end
    end

    // Address is latched on entry to StReq so it stays put through StWait.
    always_comb begin
        addr_d = addr_q;
        if (state_d == StReq) begin
            addr_d = ADDR_W'(BASE_ADDR + (32'(nl_d) - ACTIVE_FIRST) * PIXELS + 32'(pix_d));
        end
    end

    // Outputs
    always_comb begin
        write_o  = 1'b0;
        mem_rd   = 1'b0;
        busy     = (state_q != StIdle);
        data_o   = data_q;
        mem_addr = addr_q;
        overrun  = overrun_q;
        unique case (state_q)
            StReq:  mem_rd  = 1'b1;
            StPush: write_o = 1'b1;
            StBlank: begin
                write_o = 1'b1;
`ifdef LINE_FETCHER_TESTPAT_EN
                data_o  = act_q ? ({pix_q[7:5], 5'b0} ^ {5'b0, nl_q[2:0]}) : BLANK_LEVEL;
`else
                data_o  = BLANK_LEVEL;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_fetcher.sv
module tb_line_fetcher;

    logic        clk;
    logic        reset;
    logic        rst2_n;
    logic [7:0]  line_i;
    logic        ready_i;
    logic        write_o;
    logic [7:0]  data_o;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        busy;
    logic        overrun;

    logic        write2;
    logic [7:0]  data2;
    logic [15:0] mem_addr2;
    logic        mem_rd2;
    logic        busy2;
    logic        overrun2;

    int checks = 0;
    int errors = 0;

    line_fetcher u_dut (
        .clk       (clk),
        .reset     (reset),
        .line_i    (line_i),
        .ready_i   (ready_i),
        .write_o   (write_o),
        .data_o    (data_o),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Short field to exercise the line-number wrap with the 8-bit line_i.
    line_fetcher #(
        .PIXELS      (4),
        .TOTAL_LINES (100),
        .BLANK_LEVEL (8'hA5)
    ) u_wrap (
        .clk       (clk),
        .reset     (rst2_n),
        .line_i    (line_i),
        .ready_i   (ready_i),
        .write_o   (write2),
        .data_o    (data2),
        .mem_addr  (mem_addr2),
        .mem_rd    (mem_rd2),
        .mem_data  (8'h00),
        .mem_valid (1'b0),
        .busy      (busy2),
        .overrun   (overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memory: returns addr[7:0], data valid two cycles after mem_rd.
    logic [1:0]  lat;
    logic [15:0] maddr;
    always @(posedge clk) begin
        if (mem_rd) begin
            lat   <= 2'd2;
            maddr <= mem_addr;
        end else if (lat != 2'd0) begin
            lat <= lat - 2'd1;
        end
    end
    assign mem_valid = (lat == 2'd1);
    assign mem_data  = mem_valid ? maddr[7:0] : 8'h00;

    // Monitor: record accepted bytes, read addresses and overrun pulses.
    logic [7:0]  got[$];
    logic [15:0] rd_q[$];
    logic [7:0]  got2[$];
    int          ovr_cnt = 0;
    int          rd2_cnt = 0;
    always @(negedge clk) begin
        if (write_o && ready_i) got.push_back(data_o);
        if (mem_rd) rd_q.push_back(mem_addr);
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (write2 && ready_i) got2.push_back(data2);
        if (mem_rd2) rd2_cnt <= rd2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    // Wait for busy to rise and fall again; returns the busy cycle count.
    task automatic run_line(input string tag, input int limit, output int busy_cyc);
        int n;
        n = 0;
        busy_cyc = 0;
        while (n < limit) begin
            tick();
            n++;
            if (busy) busy_cyc++;
            else if (busy_cyc > 0) break;
        end
        chk({tag, "_done"}, 32'(n < limit), 32'd1);
    endtask

    int base, rdb, ovb, cyc, bad, n;
    logic [7:0] d0;

    initial begin
        reset   = 1'b0;
        rst2_n  = 1'b0;
        line_i  = 8'd19;
        ready_i = 1'b1;
        #12;
        // Reset state
        chk("rst_write", 32'(write_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        drive();
        reset = 1'b1;
        rdb = rd_q.size();
        repeat (5) tick();
        chk("quiet_rd", 32'(rd_q.size() - rdb), 32'd0);
        chk("quiet_busy", 32'(busy), 32'd0);

`ifndef LINE_FETCHER_TESTPAT_EN
        // Active line: 19 -> 20 gives nl=21, row 1
        base = got.size();
        rdb  = rd_q.size();
        drive();
        line_i = 8'd20;
        tick();
        chk("act_evt_busy", 32'(busy), 32'd0);
        tick();
        chk("act_req_rd", 32'(mem_rd), 32'd1);
        chk("act_req_addr", 32'(mem_addr), 32'h100);
        run_line("act", 3000, cyc);
        chk("act_cycles", 32'(cyc), 32'd1023);
        chk("act_count", 32'(got.size() - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got[base+i] !== 8'(i)) bad++;
        chk("act_data", 32'(bad), 32'd0);
        chk("act_reads", 32'(rd_q.size() - rdb), 32'd256);
        chk("act_first_addr", 32'(rd_q[rdb]), 32'h100);
`endif

        // Line 255 -> nl=256, beyond the active region: blank at full rate
        base = got.size();
        rdb  = rd_q.size();
        drive();
        line_i = 8'd255;
        run_line("blank", 1000, cyc);
        chk("blank_cycles", 32'(cyc), 32'd256);
        chk("blank_count", 32'(got.size() - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got[base+i] !== 8'h00) bad++;
        chk("blank_data", 32'(bad), 32'd0);
        chk("blank_reads", 32'(rd_q.size() - rdb), 32'd0);

`ifndef LINE_FETCHER_TESTPAT_EN
        // ready_i stalls during an active fetch (nl=41)
        base = got.size();
        drive();
        line_i = 8'd40;
        n = 0;
        while (got.size() < base + 10 && n < 200) begin tick(); n++; end
        drive();
        ready_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!write_o && n < 20);
        d0 = data_o;
        chk("stall_pix", 32'(d0), 32'(got.size() - base));
        drive();
        tick();
        chk("stall1_write", 32'(write_o), 32'd1);
        chk("stall1_data", 32'(data_o), 32'(d0));
        drive();
        tick();
        chk("stall2_write", 32'(write_o), 32'd1);
        chk("stall2_data", 32'(data_o), 32'(d0));
        drive();
        ready_i = 1'b1;
        run_line("stall", 3000, cyc);
        chk("stall_count", 32'(got.size() - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got[base+i] !== 8'(i)) bad++;
        chk("stall_data_order", 32'(bad), 32'd0);
`endif

        // Asynchronous reset while holding a byte
        drive();
        ready_i = 1'b0;
        line_i  = 8'd70;
        n = 0;
        do begin tick(); n++; end while (!write_o && n < 20);
        chk("pre_rst_write", 32'(write_o), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_write", 32'(write_o), 32'd0);
        chk("arst_rd", 32'(mem_rd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        drive();
        reset = 1'b1;
        rdb = rd_q.size();
        repeat (5) tick();
        chk("arst_quiet_rd", 32'(rd_q.size() - rdb), 32'd0);
        chk("arst_quiet_busy", 32'(busy), 32'd0);
        ready_i = 1'b1;

`ifndef LINE_FETCHER_TESTPAT_EN
        // Line change with a read outstanding after 100 bytes (nl 51 -> 61)
        base = got.size();
        drive();
        line_i = 8'd50;
        n = 0;
        while (got.size() < base + 100 && n < 1000) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; end while (!mem_rd && n < 10);
        ovb = ovr_cnt;
        drive();
        line_i = 8'd60;
        tick();
        chk("ovr_before_count", 32'(got.size() - base), 32'd100);
        chk("ovr_evt_pulse", 32'(overrun), 32'd0);
        base = got.size();
        rdb  = rd_q.size();
        tick();
        chk("ovr_pulse", 32'(overrun), 32'd1);
        run_line("ovr", 3000, cyc);
        chk("ovr_pulses", 32'(ovr_cnt - ovb), 32'd1);
        chk("ovr_count", 32'(got.size() - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got[base+i] !== 8'(i)) bad++;
        chk("ovr_data", 32'(bad), 32'd0);
        chk("ovr_reads", 32'(rd_q.size() - rdb), 32'd256);
        chk("ovr_first_addr", 32'(rd_q[rdb]), 32'h2900);
`else
        // Test pattern: 29 -> 30 gives nl=31
        drive();
        line_i = 8'd29;
        run_line("pat29", 1000, cyc);
        base = got.size();
        rdb  = rd_q.size();
        drive();
        line_i = 8'd30;
        run_line("pat30", 1000, cyc);
        chk("pat_cycles", 32'(cyc), 32'd256);
        chk("pat_count", 32'(got.size() - base), 32'd256);
        chk("pat_reads", 32'(rd_q.size() - rdb), 32'd0);
        chk("pat_0", 32'(got[base]), 32'h07);
        chk("pat_45", 32'(got[base+'h45]), 32'h47);
        chk("pat_ff", 32'(got[base+'hff]), 32'hE7);
`endif

        // Wrap: TOTAL_LINES=100, line 99 -> nl=0 (blank, no memory)
        drive();
        line_i = 8'd98;
        drive();
        rst2_n = 1'b1;
        tick();
        tick();
        chk("wrap_idle", 32'(busy2), 32'd0);
        base = got2.size();
        rdb  = rd2_cnt;
        drive();
        line_i = 8'd99;
        cyc = 0;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (busy2) cyc++;
            else if (cyc > 0) break;
        end
        chk("wrap_done", 32'(n < 50), 32'd1);
        chk("wrap_cycles", 32'(cyc), 32'd4);
        chk("wrap_count", 32'(got2.size() - base), 32'd4);
        bad = 0;
        for (int i = 0; i < 4; i++) if (got2[base+i] !== 8'hA5) bad++;
        chk("wrap_data", 32'(bad), 32'd0);
        chk("wrap_reads", 32'(rd2_cnt - rdb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
